fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit_pkg.sv | 32 +++
 rtl/fwd_hazard_unit_fwd_select.sv | 41 ++++
 rtl/fwd_hazard_unit.sv | 130 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit_pkg
//  Description : Shared forwarding encodings and the stage-tracking record
//                used by the forwarding / hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fwd_hazard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Destination addresses are stored zero-extended so the record is
    // independent of the AW parameter; AW must not exceed this width.
    localparam int MAX_AW = 16;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

    function automatic logic writes_reg(input stage_t s, input logic [MAX_AW-1:0] addr);
        return s.valid && s.reg_write && (s.rd == addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_unit_fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : Per-operand bypass priority: MEM result, then WB result,
//                otherwise the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
    import fwd_hazard_unit_pkg::*;
#(
    parameter int AW                 = 5,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic [AW-1:0] rs_i,
    input  logic          rs_used_i,
    input  stage_t        m_i,
    input  stage_t        w_i,
    output logic [1:0]    sel_o
);

    logic [MAX_AW-1:0] w_addr;
    logic              w_zero_block;
    logic              w_unused;

    assign w_addr       = MAX_AW'(rs_i);
    assign w_zero_block = (ZERO_REG_HARDWIRED != 0) && (rs_i == '0);
    assign w_unused     = ^{m_i.is_load, w_i.is_load};

    always_comb begin
        sel_o = FWD_RF;
        if (rs_used_i && !w_zero_block) begin
            if (writes_reg(m_i, w_addr)) begin
                sel_o = FWD_MEM;
            end else if (writes_reg(w_i, w_addr)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : Operand forwarding select and load-use / redirect hazard
//                control for a 5-stage pipeline. Define FWD_HAZARD_PERF_EN
//                to add stall / flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int AW                 = 5,
    parameter int NUM_SRC            = 2,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [NUM_SRC*AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]    id_rs_used,
    input  logic [AW-1:0]         id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  ex_redirect,
    output logic [2*NUM_SRC-1:0]  fwd_sel,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    stage_t                e_q, e_d, m_q, w_q;
    logic [NUM_SRC*AW-1:0] e_rs_q, e_rs_d;
    logic [NUM_SRC-1:0]    e_rs_used_q, e_rs_used_d;

    logic [NUM_SRC-1:0]    w_lu_hit;
    logic                  w_load_use;
    logic                  w_stall;
    logic                  w_flush_e;

    // A used ID operand matching the load in EX; x0 never creates a hazard
    // when it is hardwired.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lu
        assign w_lu_hit[i] = id_rs_used[i]
                           && (MAX_AW'(id_rs[i*AW +: AW]) == e_q.rd)
                           && !((ZERO_REG_HARDWIRED != 0) && (id_rs[i*AW +: AW] == '0));
    end

    assign w_load_use = id_valid && e_q.valid && e_q.is_load && e_q.reg_write && (|w_lu_hit);
    assign w_stall    = w_load_use && !ex_redirect;
    assign w_flush_e  = ex_redirect || w_load_use;

    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign flush_d = ex_redirect;
    assign flush_e = w_flush_e;

    always_comb begin
        e_d         = STAGE_BUBBLE;
        e_rs_d      = '0;
        e_rs_used_d = '0;
        if (!w_flush_e) begin
            e_d.valid     = id_valid;
            e_d.rd        = MAX_AW'(id_rd);
            e_d.reg_write = id_reg_write;
            e_d.is_load   = id_is_load;
            e_rs_d        = id_rs;
            e_rs_used_d   = id_valid ? id_rs_used : '0;
        end
    end

    // M and W always advance; only E takes a bubble on a stall or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q         <= STAGE_BUBBLE;
            m_q         <= STAGE_BUBBLE;
            w_q         <= STAGE_BUBBLE;
            e_rs_q      <= '0;
            e_rs_used_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= e_q;
            w_q         <= m_q;
            e_rs_q      <= e_rs_d;
            e_rs_used_q <= e_rs_used_d;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_select #(
            .AW                 (AW),
            .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
        ) u_fwd_select (
            .rs_i      (e_rs_q[i*AW +: AW]),
            .rs_used_i (e_rs_used_q[i] & e_q.valid),
            .m_i       (m_q),
            .w_i       (w_q),
            .sel_o     (fwd_sel[2*i +: 2])
        );
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (w_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (ex_redirect) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_unit
//  Description : Directed self-checking bench for fwd_hazard_unit with a
//                per-cycle pipeline reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int ZR = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [NS*AW-1:0] id_rs;
    logic [NS-1:0] id_rs_used;
    logic [AW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_is_load;
    logic          ex_redirect;
    logic [2*NS-1:0] fwd_sel;
    logic          stall_f, stall_d, flush_d, flush_e;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0]   perf_stall_cnt, perf_flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit seen_reset = 1'b0;

    fwd_hazard_unit #(
        .AW                 (AW),
        .NUM_SRC            (NS),
        .ZERO_REG_HARDWIRED (ZR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .ex_redirect  (ex_redirect),
        .fwd_sel      (fwd_sel),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one instruction record per tracked stage.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
        int rs0, rs1;
        bit u0, u1;
    } ins_t;

    ins_t mx, mm, mw;

    function automatic ins_t bubble();
        ins_t b;
        b.v = 0; b.rd = 0; b.rw = 0; b.ld = 0;
        b.rs0 = 0; b.rs1 = 0; b.u0 = 0; b.u1 = 0;
        return b;
    endfunction

    function automatic ins_t id_now();
        ins_t n;
        n = bubble();
        if (id_valid) begin
            n.v = 1; n.rd = int'(id_rd); n.rw = id_reg_write; n.ld = id_is_load;
            n.rs0 = int'(id_rs[4:0]); n.rs1 = int'(id_rs[9:5]);
            n.u0 = id_rs_used[0]; n.u1 = id_rs_used[1];
        end
        return n;
    endfunction

    function automatic bit reads(ins_t r, int addr);
        if (ZR != 0 && addr == 0) return 0;
        return (r.u0 && r.rs0 == addr) || (r.u1 && r.rs1 == addr);
    endfunction

    function automatic bit lu_exp();
        return mx.v && mx.ld && mx.rw && reads(id_now(), mx.rd);
    endfunction

    function automatic logic [1:0] pick(bit used, int addr);
        if (!mx.v || !used || (ZR != 0 && addr == 0)) return 2'b00;
        if (mm.v && mm.rw && mm.rd == addr) return 2'b10;
        if (mw.v && mw.rw && mw.rd == addr) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] fwd_exp();
        return {pick(mx.u1, mx.rs1), pick(mx.u0, mx.rs0)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            seen_reset <= 1'b1;
            mx <= bubble(); mm <= bubble(); mw <= bubble();
        end else begin
            mw <= mm;
            mm <= mx;
            mx <= (ex_redirect || lu_exp()) ? bubble() : id_now();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (seen_reset && !rst) begin
            chk("model_fwd_sel", 32'(fwd_sel), 32'(fwd_exp()));
            chk("model_stall_f", 32'(stall_f), 32'(lu_exp() && !ex_redirect));
            chk("model_stall_d", 32'(stall_d), 32'(lu_exp() && !ex_redirect));
            chk("model_flush_d", 32'(flush_d), 32'(ex_redirect));
            chk("model_flush_e", 32'(flush_e), 32'(ex_redirect || lu_exp()));
        end
    end

    task automatic drive(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                         input int rd, input bit rw, input bit ld, input bit redir);
        id_valid     = v;
        id_rs        = {5'(rs1), 5'(rs0)};
        id_rs_used   = used;
        id_rd        = 5'(rd);
        id_reg_write = rw;
        id_is_load   = ld;
        ex_redirect  = redir;
    endtask

    task automatic nop();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) nxt();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_fwd"}, 32'(fwd_sel), 32'h0);
        chk({nm, "_stall"}, 32'({stall_f, stall_d}), 32'h0);
        chk({nm, "_flush"}, 32'({flush_d, flush_e}), 32'h0);
    endtask

    task automatic load_use_pair();
        drive(1, 0, 0, 2'b00, 3, 1, 1, 0); nxt();
        drive(1, 3, 0, 2'b01, 11, 1, 0, 0); nxt();
        nxt();
        nop(); nxt();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        repeat (2) nxt();
        rst = 1'b0;

        mid(); chk_all_zero("reset");
        nxt();

        // add x5 then consumer of x5 -> MEM bypass on operand 0
        drive(1, 0, 0, 2'b00, 5, 1, 0, 0); nxt();
        drive(1, 5, 0, 2'b01, 6, 1, 0, 0); nxt();
        nop(); mid(); chk("mem_fwd_rs1", 32'(fwd_sel), 32'h2); nxt();
        drain();

        // add x9, nop, consumer on rs2 -> WB bypass
        drive(1, 0, 0, 2'b00, 9, 1, 0, 0); nxt();
        nop(); nxt();
        drive(1, 1, 9, 2'b10, 10, 1, 0, 0); nxt();
        nop(); mid(); chk("wb_fwd_rs2", 32'(fwd_sel), 32'h4); nxt();
        drain();

        // x9 in both M and W -> MEM wins
        drive(1, 0, 0, 2'b00, 9, 1, 0, 0); nxt();
        drive(1, 0, 0, 2'b00, 9, 1, 0, 0); nxt();
        drive(1, 1, 9, 2'b10, 10, 1, 0, 0); nxt();
        nop(); mid(); chk("mem_over_wb", 32'(fwd_sel), 32'h8); nxt();
        drain();

        // lw x3 followed by reader of x3 -> one stall cycle, then WB bypass
        drive(1, 0, 0, 2'b00, 3, 1, 1, 0); nxt();
        drive(1, 3, 0, 2'b01, 11, 1, 0, 0);
        mid(); chk("lu_stall", 32'({stall_f, stall_d, flush_e, flush_d}), 32'hE); nxt();
        mid(); chk("lu_stall_done", 32'({stall_f, stall_d, flush_e}), 32'h0); nxt();
        nop(); mid(); chk("lu_then_wb", 32'(fwd_sel), 32'h1); nxt();
        drain();

        // load-use coincident with redirect -> redirect wins, E bubbled
        drive(1, 0, 0, 2'b00, 3, 1, 1, 0); nxt();
        drive(1, 3, 0, 2'b01, 4, 1, 1, 1);
        mid(); chk("redir_wins", 32'({flush_d, flush_e, stall_f, stall_d}), 32'hC); nxt();
        drive(1, 4, 0, 2'b01, 12, 1, 0, 0);
        mid(); chk("redir_e_bubble", 32'(stall_f), 32'h0); nxt();
        nop(); mid(); chk("redir_no_fwd", 32'(fwd_sel), 32'h0); nxt();
        drain();

        // x0 is never forwarded or stalled on
        drive(1, 0, 0, 2'b00, 0, 1, 0, 0); nxt();
        drive(1, 0, 0, 2'b11, 13, 1, 0, 0); nxt();
        nop(); mid(); chk("x0_no_fwd", 32'(fwd_sel), 32'h0); nxt();
        drive(1, 0, 0, 2'b00, 0, 1, 1, 0); nxt();
        drive(1, 0, 0, 2'b01, 14, 1, 0, 0);
        mid(); chk("x0_no_stall", 32'(stall_f), 32'h0); nxt();
        drain();

        // unused operand matching x7 -> no bypass
        drive(1, 0, 0, 2'b00, 7, 1, 0, 0); nxt();
        drive(1, 1, 7, 2'b01, 15, 1, 0, 0); nxt();
        nop(); mid(); chk("unused_no_fwd", 32'(fwd_sel), 32'h0); nxt();
        drain();

        // reset during a load-use stall
        drive(1, 0, 0, 2'b00, 3, 1, 1, 0); nxt();
        drive(1, 3, 0, 2'b01, 11, 1, 0, 0);
        mid(); chk("pre_rst_stall", 32'(stall_f), 32'h1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        mid(); chk_all_zero("rst_mid_stall"); nxt();
        drain();

`ifdef FWD_HAZARD_PERF_EN
        chk("perf_clr_stall", perf_stall_cnt, 32'd0);
        chk("perf_clr_flush", perf_flush_cnt, 32'd0);
        repeat (3) load_use_pair();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1); nxt();
        nop(); nxt();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1); nxt();
        nop(); nxt();
        mid();
        chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
        chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
`else
        load_use_pair();
`endif

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
